// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared widths, funct3 codes and stage register layouts for the branch resolver
package branch_pkg;

    localparam int PHT_IDX_W = 6;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic                 valid;
        logic                 is_branch;
        logic                 predict;
        logic [PHT_IDX_W-1:0] pht_idx;
        logic [31:0]          pc;
    } br_idex_t;

    typedef struct packed {
        logic                 valid;
        logic                 is_branch;
        logic                 predict;
        logic [PHT_IDX_W-1:0] pht_idx;
        logic [31:0]          pc;
        logic                 taken;
        logic [31:0]          target;
    } br_exmem_t;

endpackage

// File: rtl/branch_compare.sv
// rtl/branch_compare.sv - combinational conditional-branch outcome from operands and funct3
module branch_compare
    import branch_pkg::*;
(
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [2:0]  funct3,
    output logic        taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = (rs1 <  rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - ID/EX/MEM branch resolution, predictor update and redirect; BRANCH_STATS_EN adds counters
module branch_resolver
    import branch_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 id_valid,
    input  logic                 id_is_branch,
    input  logic                 id_predict_btaken,
    input  logic [PHT_IDX_W-1:0] id_pht_idx,
    input  logic [31:0]          id_q_pc,
    input  logic [31:0]          ex_rs1_data,
    input  logic [31:0]          ex_rs2_data,
    input  logic [2:0]           ex_funct3,
    input  logic [31:0]          ex_imm,
    output logic                 mem_q_is_branch,
    output logic                 mem_q_jump_taken,
    output logic [PHT_IDX_W-1:0] mem_q_pht_idx,
    output logic                 mem_mispredict,
    output logic [31:0]          mem_redirect_pc,
    output logic [31:0]          branch_count_o,
    output logic [31:0]          mispredict_count_o
);

    br_idex_t  ex_q;
    br_exmem_t mem_q;
    logic      ex_taken;
    logic      mem_fire;

    branch_compare u_compare (
        .rs1    (ex_rs1_data),
        .rs2    (ex_rs2_data),
        .funct3 (ex_funct3),
        .taken  (ex_taken)
    );

    assign mem_fire         = mem_q.valid & mem_q.is_branch & ~stall_i;
    assign mem_q_is_branch  = mem_fire;
    assign mem_q_jump_taken = mem_q.taken;
    assign mem_q_pht_idx    = mem_q.pht_idx;
    assign mem_mispredict   = mem_fire & (mem_q.taken != mem_q.predict);

    // An empty MEM slot reports 0 so the redirect bus is quiet after reset and bubbles.
    assign mem_redirect_pc  = !mem_q.valid ? 32'd0
                            : (mem_q.taken ? mem_q.target : mem_q.pc + 32'd4);

    // mem_mispredict already implies no stall; flush overrides stall.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i || mem_mispredict) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else if (!stall_i) begin
            ex_q.valid      <= id_valid;
            ex_q.is_branch  <= id_is_branch;
            ex_q.predict    <= id_predict_btaken;
            ex_q.pht_idx    <= id_pht_idx;
            ex_q.pc         <= id_q_pc;
            mem_q.valid     <= ex_q.valid;
            mem_q.is_branch <= ex_q.is_branch;
            mem_q.predict   <= ex_q.predict;
            mem_q.pht_idx   <= ex_q.pht_idx;
            mem_q.pc        <= ex_q.pc;
            mem_q.taken     <= ex_taken;
            mem_q.target    <= ex_q.pc + ex_imm;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (mem_fire)
                branch_count <= branch_count + 32'd1;
            if (mem_mispredict)
                mispredict_count <= mispredict_count + 32'd1;
        end
    end

    assign branch_count_o     = branch_count;
    assign mispredict_count_o = mispredict_count;
`else
    assign branch_count_o     = 32'd0;
    assign mispredict_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - scoreboard bench for branch_resolver
module tb_branch_resolver;
    import branch_pkg::*;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 stall_i = 1'b0;
    logic                 flush_i = 1'b0;
    logic                 id_valid = 1'b0;
    logic                 id_is_branch = 1'b0;
    logic                 id_predict_btaken = 1'b0;
    logic [PHT_IDX_W-1:0] id_pht_idx = '0;
    logic [31:0]          id_q_pc = '0;
    logic [31:0]          ex_rs1_data = '0;
    logic [31:0]          ex_rs2_data = '0;
    logic [2:0]           ex_funct3 = '0;
    logic [31:0]          ex_imm = '0;
    logic                 mem_q_is_branch;
    logic                 mem_q_jump_taken;
    logic [PHT_IDX_W-1:0] mem_q_pht_idx;
    logic                 mem_mispredict;
    logic [31:0]          mem_redirect_pc;
    logic [31:0]          branch_count_o;
    logic [31:0]          mispredict_count_o;

    always #5 clk_i = ~clk_i;

    branch_resolver dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .stall_i            (stall_i),
        .flush_i            (flush_i),
        .id_valid           (id_valid),
        .id_is_branch       (id_is_branch),
        .id_predict_btaken  (id_predict_btaken),
        .id_pht_idx         (id_pht_idx),
        .id_q_pc            (id_q_pc),
        .ex_rs1_data        (ex_rs1_data),
        .ex_rs2_data        (ex_rs2_data),
        .ex_funct3          (ex_funct3),
        .ex_imm             (ex_imm),
        .mem_q_is_branch    (mem_q_is_branch),
        .mem_q_jump_taken   (mem_q_jump_taken),
        .mem_q_pht_idx      (mem_q_pht_idx),
        .mem_mispredict     (mem_mispredict),
        .mem_redirect_pc    (mem_redirect_pc),
        .branch_count_o     (branch_count_o),
        .mispredict_count_o (mispredict_count_o)
    );

    typedef struct {
        logic        v;
        logic        br;
        logic        pred;
        logic [5:0]  idx;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [2:0]  f3;
    } instr_t;

    typedef struct {
        logic        taken;
        logic [5:0]  idx;
        logic        mis;
        logic [31:0] redirect;
    } exp_t;

    exp_t   sb[$];
    instr_t bub;
    instr_t m_ex;
    instr_t m_mem;
    int     n_checks = 0;
    int     n_pass = 0;

    function automatic logic ref_taken(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t make_exp(instr_t i);
        exp_t e;
        e.taken    = ref_taken(i.f3, i.rs1, i.rs2);
        e.idx      = i.idx;
        e.mis      = e.taken != i.pred;
        e.redirect = e.taken ? i.pc + i.imm : i.pc + 32'd4;
        return e;
    endfunction

    function automatic instr_t mk(logic [31:0] pc, logic [2:0] f3, logic [31:0] rs1,
                                  logic [31:0] rs2, logic [31:0] imm, logic pred, logic [5:0] idx);
        instr_t i;
        i.v = 1'b1; i.br = 1'b1; i.pred = pred; i.idx = idx;
        i.pc = pc; i.rs1 = rs1; i.rs2 = rs2; i.imm = imm; i.f3 = f3;
        return i;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    // One clock: drive ID/EX and controls at negedge, check MEM outputs, then advance the model.
    task automatic step(instr_t id_in, bit stall, bit flush, bit rst);
        exp_t e;
        bit   fire;
        bit   mis;
        @(negedge clk_i);
        rst_i             = rst;
        stall_i           = stall;
        flush_i           = flush;
        id_valid          = id_in.v;
        id_is_branch      = id_in.br;
        id_predict_btaken = id_in.pred;
        id_pht_idx        = id_in.idx;
        id_q_pc           = id_in.pc;
        ex_rs1_data       = m_ex.rs1;
        ex_rs2_data       = m_ex.rs2;
        ex_funct3         = m_ex.f3;
        ex_imm            = m_ex.imm;
        #1;
        fire = m_mem.v && m_mem.br && !stall;
        mis  = 1'b0;
        check("strobe", {31'd0, mem_q_is_branch}, {31'd0, fire});
        if (fire) begin
            if (sb.size() == 0) begin
                check("sb_depth", 32'(sb.size()), 32'd1);
            end else begin
                e   = sb.pop_front();
                mis = e.mis;
                check("jump_taken", {31'd0, mem_q_jump_taken}, {31'd0, e.taken});
                check("pht_idx", {26'd0, mem_q_pht_idx}, {26'd0, e.idx});
                check("redirect_pc", mem_redirect_pc, e.redirect);
            end
        end
        check("mispredict", {31'd0, mem_mispredict}, {31'd0, mis});
        if (rst) begin
            m_ex  = bub;
            m_mem = bub;
            sb.delete();
        end else if (flush || mis) begin
            if (m_mem.v && m_mem.br && !fire && sb.size() > 0)
                void'(sb.pop_front());
            m_ex  = bub;
            m_mem = bub;
        end else if (!stall) begin
            m_mem = m_ex;
            if (m_ex.v && m_ex.br)
                sb.push_back(make_exp(m_ex));
            m_ex = id_in;
        end
    endtask

    initial begin
        instr_t x;
        bub   = '{default: '0};
        m_ex  = bub;
        m_mem = bub;

        step(bub, 0, 0, 1);
        step(bub, 0, 0, 1);
        step(bub, 0, 0, 0);
        check("rst_redirect", mem_redirect_pc, 32'd0);
        check("rst_pht_idx", {26'd0, mem_q_pht_idx}, 32'd0);
        check("rst_taken", {31'd0, mem_q_jump_taken}, 32'd0);
        check("rst_branch_cnt", branch_count_o, 32'd0);
        check("rst_mis_cnt", mispredict_count_o, 32'd0);

        // BEQ mispredict; the two younger instructions must be squashed
        step(mk(32'h100, F3_BEQ, 5, 5, 32'h40, 0, 6'h2A), 0, 0, 0);
        x = mk(32'h104, F3_BNE, 1, 2, 32'h8, 0, 6'h01);
        x.br = 1'b0;
        step(x, 0, 0, 0);
        step(mk(32'h108, F3_BNE, 1, 2, 32'h8, 0, 6'h02), 0, 0, 0);
        check("beq_mispredict", {31'd0, mem_mispredict}, 32'd1);
        check("beq_redirect", mem_redirect_pc, 32'h140);
        check("beq_pht_idx", {26'd0, mem_q_pht_idx}, 32'h2A);
        repeat (3) step(bub, 0, 0, 0);

        // signed vs unsigned less-than on the same operands
        step(mk(32'h200, F3_BLT, 32'hFFFFFFFF, 1, 32'h20, 1, 6'h03), 0, 0, 0);
        step(mk(32'h204, F3_BLTU, 32'hFFFFFFFF, 1, 32'h20, 1, 6'h04), 0, 0, 0);
        step(bub, 0, 0, 0);
        check("blt_no_mispredict", {31'd0, mem_mispredict}, 32'd0);
        step(bub, 0, 0, 0);
        check("bltu_redirect", mem_redirect_pc, 32'h208);
        repeat (2) step(bub, 0, 0, 0);

        // branch held in MEM for three stall cycles
        step(mk(32'h300, F3_BNE, 1, 2, 32'h10, 1, 6'h05), 0, 0, 0);
        step(bub, 0, 0, 0);
        repeat (3) step(bub, 1, 0, 0);
        step(bub, 0, 0, 0);
        step(bub, 0, 0, 0);

        // flush with branches in EX and ID
        step(mk(32'h400, F3_BEQ, 3, 3, 32'h10, 0, 6'h06), 0, 0, 0);
        step(mk(32'h404, F3_BEQ, 3, 3, 32'h10, 0, 6'h07), 0, 1, 0);
        repeat (3) step(bub, 0, 0, 0);

        // flush coinciding with a mispredict in MEM still updates
        step(mk(32'h500, F3_BGEU, 9, 2, 32'h30, 0, 6'h08), 0, 0, 0);
        step(bub, 0, 0, 0);
        step(bub, 0, 1, 0);
        check("flush_mis_strobe", {31'd0, mem_q_is_branch}, 32'd1);
        step(bub, 0, 0, 0);

        // fall-through wraps at the top of the address space
        step(mk(32'hFFFFFFFC, F3_BGE, 0, 5, 32'h40, 1, 6'h09), 0, 0, 0);
        step(bub, 0, 0, 0);
        step(bub, 0, 0, 0);
        check("wrap_redirect", mem_redirect_pc, 32'h0);
        step(bub, 0, 0, 0);

        // reserved funct3 resolves not-taken, followed by a valid non-branch
        step(mk(32'h600, 3'b010, 7, 7, 32'h40, 0, 6'h0A), 0, 0, 0);
        x = mk(32'h604, F3_BEQ, 7, 7, 32'h40, 1, 6'h0B);
        x.br = 1'b0;
        step(x, 0, 0, 0);
        repeat (3) step(bub, 0, 0, 0);

        // reset with a branch in EX drops it
        step(mk(32'h700, F3_BEQ, 1, 1, 32'h40, 1, 6'h0C), 0, 0, 0);
        step(bub, 0, 0, 1);
        repeat (3) step(bub, 0, 0, 0);

        // ten branches, three of them mispredicted
        for (int i = 0; i < 10; i++) begin
            step(mk(32'h1000 + 32'(i) * 32'h10, F3_BEQ, 32'(i), 32'(i), 32'h8,
                    !(i == 2 || i == 5 || i == 8), 6'(i)), 0, 0, 0);
            step(bub, 0, 0, 0);
            step(bub, 0, 0, 0);
        end
        repeat (2) step(bub, 0, 0, 0);
`ifdef BRANCH_STATS_EN
        check("branch_count", branch_count_o, 32'd10);
        check("mispredict_count", mispredict_count_o, 32'd3);
`else
        check("branch_count", branch_count_o, 32'd0);
        check("mispredict_count", mispredict_count_o, 32'd0);
`endif
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
